// File: rtl/rv32m_pkg.sv
// Shared RV32M definitions: divider FSM states, M-extension funct3 codes, default XLEN.
package rv32m_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

    localparam logic [2:0] F3_DIV  = 3'b100;
    localparam logic [2:0] F3_DIVU = 3'b101;
    localparam logic [2:0] F3_REM  = 3'b110;
    localparam logic [2:0] F3_REMU = 3'b111;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift in the next dividend bit,
// trial-subtract the divisor on an XLEN+1 bit path, keep the difference if it did not borrow.
module div_step #(
    parameter int XLEN = 32
)(
    input  logic [XLEN-1:0] rem_i,
    input  logic [XLEN-1:0] dvd_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] rem_o,
    output logic [XLEN-1:0] dvd_o,
    output logic            q_bit_o
);

    logic [XLEN:0] rem_sh;
    logic [XLEN:0] diff;

    assign rem_sh = {rem_i, dvd_i[XLEN-1]};
    assign diff   = rem_sh - {1'b0, divisor_i};

    // The running remainder is always below the divisor, so a non-borrowing
    // difference fits in XLEN bits and the top bit alone acts as the compare.
    assign q_bit_o = ~diff[XLEN];
    assign rem_o   = q_bit_o ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
    assign dvd_o   = {dvd_i[XLEN-2:0], 1'b0};

endmodule

// File: rtl/divider_top.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Optional macro DIVIDER_EARLY_OUT_EN: divide-by-zero and signed overflow skip the CALC phase.
module divider_top
    import rv32m_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
)(
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            div_en_i,
    input  logic [XLEN-1:0] op_A_i,
    input  logic [XLEN-1:0] op_B_i,
    input  logic            signed_i,
    input  logic            rem_i,
    output logic [XLEN-1:0] result_o,
    output logic            busy_o,
    output logic            done_o
);

    localparam int CNT_W = $clog2(XLEN);

    function automatic logic [XLEN-1:0] negate_if(input logic [XLEN-1:0] v, input logic en);
        return en ? (~v + XLEN'(1)) : v;
    endfunction

    div_state_t state_q, state_d;

    logic [XLEN-1:0]  dvd_q, dvd_d;
    logic [XLEN-1:0]  rem_q, rem_d;
    logic [XLEN-1:0]  divisor_q, divisor_d;
    logic [XLEN-1:0]  raw_a_q, raw_a_d;
    logic [XLEN-1:0]  result_q, result_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             neg_quot_q, neg_quot_d;
    logic             neg_rem_q, neg_rem_d;
    logic             rem_sel_q, rem_sel_d;
    logic             b_zero_q, b_zero_d;
    logic             ovf_q, ovf_d;

    logic            a_neg_in, b_neg_in, b_zero_in, ovf_in;
    logic [XLEN-1:0] step_rem, step_dvd;
    logic            step_q;

    logic signed [XLEN-1:0] quot_fix, rem_fix;

    assign a_neg_in  = signed_i & op_A_i[XLEN-1];
    assign b_neg_in  = signed_i & op_B_i[XLEN-1];
    assign b_zero_in = (op_B_i == '0);
    assign ovf_in    = signed_i && (op_A_i == {1'b1, {(XLEN-1){1'b0}}}) && (op_B_i == '1);

    div_step #(.XLEN(XLEN)) u_step (
        .rem_i     (rem_q),
        .dvd_i     (dvd_q),
        .divisor_i (divisor_q),
        .rem_o     (step_rem),
        .dvd_o     (step_dvd),
        .q_bit_o   (step_q)
    );

    // Sign restoration first, then the RISC-V special results override it.
    always_comb begin
        quot_fix = negate_if(dvd_q, neg_quot_q);
        rem_fix  = negate_if(rem_q, neg_rem_q);
        if (b_zero_q) begin
            quot_fix = '1;
            rem_fix  = raw_a_q;
        end else if (ovf_q) begin
            quot_fix = raw_a_q;
            rem_fix  = '0;
        end
    end

    always_comb begin
        state_d    = state_q;
        dvd_d      = dvd_q;
        rem_d      = rem_q;
        divisor_d  = divisor_q;
        raw_a_d    = raw_a_q;
        result_d   = result_q;
        cnt_d      = cnt_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        rem_sel_d  = rem_sel_q;
        b_zero_d   = b_zero_q;
        ovf_d      = ovf_q;

        case (state_q)
            IDLE: begin
                if (div_en_i) begin
                    dvd_d      = negate_if(op_A_i, a_neg_in);
                    divisor_d  = negate_if(op_B_i, b_neg_in);
                    raw_a_d    = op_A_i;
                    rem_d      = '0;
                    cnt_d      = CNT_W'(XLEN-1);
                    neg_quot_d = a_neg_in ^ b_neg_in;
                    neg_rem_d  = a_neg_in;
                    rem_sel_d  = rem_i;
                    b_zero_d   = b_zero_in;
                    ovf_d      = ovf_in;
`ifdef DIVIDER_EARLY_OUT_EN
                    state_d    = (b_zero_in || ovf_in) ? FIX : CALC;
`else
                    state_d    = CALC;
`endif
                end
            end
            CALC: begin
                rem_d = step_rem;
                dvd_d = step_dvd | {{(XLEN-1){1'b0}}, step_q};
                if (cnt_q == '0) begin
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            FIX: begin
                result_d = rem_sel_q ? rem_fix : quot_fix;
                state_d  = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            dvd_q      <= '0;
            rem_q      <= '0;
            divisor_q  <= '0;
            raw_a_q    <= '0;
            result_q   <= '0;
            cnt_q      <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            rem_sel_q  <= 1'b0;
            b_zero_q   <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            dvd_q      <= dvd_d;
            rem_q      <= rem_d;
            divisor_q  <= divisor_d;
            raw_a_q    <= raw_a_d;
            result_q   <= result_d;
            cnt_q      <= cnt_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            rem_sel_q  <= rem_sel_d;
            b_zero_q   <= b_zero_d;
            ovf_q      <= ovf_d;
        end
    end

    assign result_o = result_q;
    assign busy_o   = (state_q == CALC) || (state_q == FIX);
    assign done_o   = (state_q == DONE);

endmodule
